wb_write_arbiter: RTL and testbench

//   Writer side of the regfile write port (rd/we/wdata). Merges two result producers into
//   the single write port: ALU (single-cycle, always accepted) and LSU (multi-cycle loads,

---
 rtl/wb_write_arbiter.sv | 91 +++++++++
 tb/tb_wb_write_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges ALU results and queued LSU loads onto one regfile write port
//   clk, reset            clock and asynchronous active-high reset
//   alu_valid/rd/data     single-cycle ALU result, never stalled
//   lsu_valid/rd/data     LSU load result offered; lsu_ready accepts it into an in-order FIFO
//   rf_we/rd/wdata        registered regfile write port
//   pend_mask             per-register live queued-write flags
//   Optional feature: define WB_SCOREBOARD_EN for a registered pend_mask (tied to 0 otherwise)
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [DW-1:0]   alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [DW-1:0]   lsu_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [DW-1:0]   rf_wdata,
  output logic [2**AW-1:0] pend_mask
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] q_rd [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] live, live_n;
  logic [PW-1:0] rptr, wptr;
  logic [PW:0] count;
  logic alu_go, pop, push, issue_q;
  assign lsu_ready = count < (PW+1)'(DEPTH);
  assign alu_go = alu_valid && alu_rd != '0;
  assign pop = !alu_go && count != '0;
  assign issue_q = pop && live[rptr];
  // A handshake with rd==0 completes but stores nothing
  assign push = lsu_valid && lsu_ready && lsu_rd != '0;
  // Live bit per slot: cleared on pop or when a younger ALU write hits the same register
  always_comb begin
    live_n = live;
    if (pop) live_n[rptr] = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (alu_go && q_rd[i] == alu_rd) live_n[i] = 1'b0;
    if (push) live_n[wptr] = !(alu_go && lsu_rd == alu_rd);
  end
  always_ff @(posedge clk)
    if (push) begin
      q_rd[wptr] <= lsu_rd;
      q_data[wptr] <= lsu_data;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      live <= '0;
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wdata <= '0;
    end else begin
      live <= live_n;
      rptr <= rptr + PW'(pop);
      wptr <= wptr + PW'(push);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      rf_we <= alu_go || issue_q;
      if (alu_go) begin
        rf_rd <= alu_rd;
        rf_wdata <= alu_data;
      end else if (issue_q) begin
        rf_rd <= q_rd[rptr];
        rf_wdata <= q_data[rptr];
      end
    end
`ifdef WB_SCOREBOARD_EN
  logic [2**AW-1:0] pend_n;
  // Built from next-state live bits so enqueue, pop and kill all show on the same edge
  always_comb begin
    pend_n = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live_n[i]) pend_n[(push && wptr == PW'(i)) ? lsu_rd : q_rd[i]] = 1'b1;
    pend_n[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) pend_mask <= '0;
    else pend_mask <= pend_n;
`else
  assign pend_mask = '0;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed vector bench for wb_write_arbiter
module tb_wb_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic alu_valid, lsu_valid, lsu_ready, rf_we;
  logic [4:0] alu_rd, lsu_rd, rf_rd;
  logic [31:0] alu_data, lsu_data, rf_wdata, pend_mask;
  int applied = 0;
  int miscompares = 0;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  typedef struct packed {
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic lv; logic [4:0] lrd; logic [31:0] ldat;
    logic we; logic [4:0] rd; logic [31:0] wd; logic rdy; logic [31:0] pend;
  } vec_t;
  localparam int NV = 26;
  vec_t v [NV];
  wb_write_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
  endtask
  initial begin
    //         av ard adat          lv lrd ldat        we rd  wd            rdy pend
    v[0]  = '{1, 5, 32'hDEADBEEF, 0, 0,  0,          1, 5,  32'hDEADBEEF, 1, 32'h0};
    v[1]  = '{0, 0, 0,            1, 7,  32'h11,     0, 5,  32'hDEADBEEF, 1, 32'h80};
    v[2]  = '{0, 0, 0,            0, 0,  0,          1, 7,  32'h11,       1, 32'h0};
    v[3]  = '{0, 0, 0,            0, 0,  0,          0, 7,  32'h11,       1, 32'h0};
    v[4]  = '{1, 1, 32'h101,      1, 10, 32'hA0,     1, 1,  32'h101,      1, 32'h400};
    v[5]  = '{1, 1, 32'h102,      1, 11, 32'hA1,     1, 1,  32'h102,      1, 32'hC00};
    v[6]  = '{1, 1, 32'h103,      1, 12, 32'hA2,     1, 1,  32'h103,      1, 32'h1C00};
    v[7]  = '{1, 1, 32'h104,      1, 13, 32'hA3,     1, 1,  32'h104,      0, 32'h3C00};
    v[8]  = '{1, 1, 32'h105,      1, 14, 32'hEE,     1, 1,  32'h105,      0, 32'h3C00};
    v[9]  = '{0, 0, 0,            1, 14, 32'hEE,     1, 10, 32'hA0,       1, 32'h3800};
    v[10] = '{0, 0, 0,            0, 0,  0,          1, 11, 32'hA1,       1, 32'h3000};
    v[11] = '{0, 0, 0,            0, 0,  0,          1, 12, 32'hA2,       1, 32'h2000};
    v[12] = '{0, 0, 0,            0, 0,  0,          1, 13, 32'hA3,       1, 32'h0};
    v[13] = '{0, 0, 0,            0, 0,  0,          0, 13, 32'hA3,       1, 32'h0};
    v[14] = '{0, 0, 0,            1, 9,  32'hAA,     0, 13, 32'hA3,       1, 32'h200};
    v[15] = '{1, 9, 32'hBB,       0, 0,  0,          1, 9,  32'hBB,       1, 32'h0};
    v[16] = '{0, 0, 0,            0, 0,  0,          0, 9,  32'hBB,       1, 32'h0};
    v[17] = '{0, 0, 0,            0, 0,  0,          0, 9,  32'hBB,       1, 32'h0};
    v[18] = '{1, 3, 32'hCC,       1, 3,  32'hDD,     1, 3,  32'hCC,       1, 32'h0};
    v[19] = '{0, 0, 0,            0, 0,  0,          0, 3,  32'hCC,       1, 32'h0};
    v[20] = '{1, 0, 32'h55,       1, 0,  32'h66,     0, 3,  32'hCC,       1, 32'h0};
    v[21] = '{1, 0, 32'h56,       0, 0,  0,          0, 3,  32'hCC,       1, 32'h0};
    v[22] = '{0, 0, 0,            1, 20, 32'h20,     0, 3,  32'hCC,       1, 32'h100000};
    v[23] = '{0, 0, 0,            1, 21, 32'h21,     1, 20, 32'h20,       1, 32'h200000};
    v[24] = '{1, 0, 32'h77,       0, 0,  0,          1, 21, 32'h21,       1, 32'h0};
    v[25] = '{0, 0, 0,            0, 0,  0,          0, 21, 32'h21,       1, 32'h0};
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset rf_we", 64'(rf_we), 0);
    chk("reset rf_rd", 64'(rf_rd), 0);
    chk("reset rf_wdata", 64'(rf_wdata), 0);
    chk("reset lsu_ready", 64'(lsu_ready), 1);
    chk("reset pend_mask", 64'(pend_mask), 0);
    for (int i = 0; i < NV; i++) begin
      drive(v[i].av, v[i].ard, v[i].adat, v[i].lv, v[i].lrd, v[i].ldat);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rf_we", i), 64'(rf_we), 64'(v[i].we));
      chk($sformatf("v%0d rf_rd", i), 64'(rf_rd), 64'(v[i].rd));
      chk($sformatf("v%0d rf_wdata", i), 64'(rf_wdata), 64'(v[i].wd));
      chk($sformatf("v%0d lsu_ready", i), 64'(lsu_ready), 64'(v[i].rdy));
      chk($sformatf("v%0d pend_mask", i), 64'(pend_mask), SB ? 64'(v[i].pend) : 64'h0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 32'h200 + 32'(i), 1, 5'(16 + i), 32'hC0 + 32'(i));
      @(posedge clk);
      #1;
    end
    drive(1, 2, 32'h2FF, 0, 0, 0);
    chk("pre-reset rf_we", 64'(rf_we), 1);
    chk("pre-reset pend_mask", 64'(pend_mask), SB ? 64'h70000 : 64'h0);
    #2 reset = 1'b1;
    #1;
    chk("async reset rf_we", 64'(rf_we), 0);
    chk("async reset rf_rd", 64'(rf_rd), 0);
    chk("async reset pend_mask", 64'(pend_mask), 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("post-reset lsu_ready", 64'(lsu_ready), 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-reset idle%0d rf_we", i), 64'(rf_we), 0);
      chk($sformatf("post-reset idle%0d pend_mask", i), 64'(pend_mask), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
